// File: rtl/room_report_arbiter.sv
// Round-robin arbiter sharing one UART TX between the Cellar and Manor
// room controllers; each grant is sent as a 5-byte frame
// (SOF, HDR, DATA hi, DATA lo, CHK) over a byte-level start/busy handshake.
// Optional feature macro: ALARM_PRIORITY_EN. When it is defined, an alarmed
// requester beats a non-alarmed one in the same cycle.
module room_report_arbiter #(
    parameter logic [7:0] SOF        = 8'h55,
    parameter int         GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        REQ_CELLAR,
    input  logic        REQ_MANOR,
    input  logic [15:0] DATA_CELLAR,
    input  logic [15:0] DATA_MANOR,
    input  logic        ALARM_CELLAR,
    input  logic        ALARM_MANOR,
    input  logic        TX_BUSY,
    output logic        TX_START,
    output logic [7:0]  TX_BYTE,
    output logic        ACK_CELLAR,
    output logic        ACK_MANOR,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT_HI,
        WAIT_LO,
        ACK,
        GAP
    } state_t;

    localparam logic [15:0] GAP_LAST =
        16'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0] LAST_IDX = 3'd4;

    state_t      state_q;
    state_t      state_d;

    // Room encoding everywhere: 0 = Cellar, 1 = Manor.
    logic        room_q;
    logic        last_q;
    logic        pick_manor;
    logic        any_req;

    logic [5:0]  seq_q;
    logic [2:0]  idx_q;
    logic [15:0] gap_q;

    logic [7:0]  hdr_q;
    logic [7:0]  dhi_q;
    logic [7:0]  dlo_q;
    logic [7:0]  chk_q;

    logic [15:0] grant_data;
    logic        grant_alarm;
    logic [7:0]  grant_hdr;
    logic [7:0]  cur_byte;
    logic        sending;

    assign any_req = REQ_CELLAR | REQ_MANOR;

    // Winner selection among the requests present while IDLE.
    always_comb begin
        pick_manor = 1'b0;
        if (REQ_CELLAR && REQ_MANOR) begin
            pick_manor = ~last_q;
`ifdef ALARM_PRIORITY_EN
            if (ALARM_CELLAR && !ALARM_MANOR) begin
                pick_manor = 1'b0;
            end else if (ALARM_MANOR && !ALARM_CELLAR) begin
                pick_manor = 1'b1;
            end
`endif
        end else begin
            pick_manor = REQ_MANOR;
        end
    end

    // Snapshot of the granted room's inputs and the header they produce.
    always_comb begin
        grant_data  = room_q ? DATA_MANOR : DATA_CELLAR;
        grant_alarm = room_q ? ALARM_MANOR : ALARM_CELLAR;
        grant_hdr   = {room_q, grant_alarm, seq_q};
    end

    // Next-state logic for the grant / byte handshake sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = START;
            end
            START: begin
                if (!TX_BUSY) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (TX_BUSY) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!TX_BUSY) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ACK;
                    end else begin
                        state_d = START;
                    end
                end
            end
            ACK: begin
                if (GAP_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Granted room is fixed at the IDLE -> GRANT transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            room_q <= 1'b0;
        end else if (state_q == IDLE && any_req) begin
            room_q <= pick_manor;
        end
    end

    // Frame bytes are frozen in GRANT so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q <= 8'h00;
            dhi_q <= 8'h00;
            dlo_q <= 8'h00;
            chk_q <= 8'h00;
        end else if (state_q == GRANT) begin
            hdr_q <= grant_hdr;
            dhi_q <= grant_data[15:8];
            dlo_q <= grant_data[7:0];
            chk_q <= grant_hdr ^ grant_data[15:8] ^ grant_data[7:0];
        end
    end

    // Byte index advances only after the UART has finished a byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 3'd0;
        end else if (state_q == GRANT) begin
            idx_q <= 3'd0;
        end else if (state_q == WAIT_LO && !TX_BUSY &&
                     idx_q != LAST_IDX) begin
            idx_q <= idx_q + 3'd1;
        end
    end

    // Sequence number and fairness pointer move once per completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q  <= 6'd0;
            last_q <= 1'b1;
        end else if (state_q == ACK) begin
            seq_q  <= seq_q + 6'd1;
            last_q <= room_q;
        end
    end

    // Inter-frame gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= 16'd0;
        end else if (state_q == ACK) begin
            gap_q <= 16'd0;
        end else if (state_q == GAP) begin
            gap_q <= gap_q + 16'd1;
        end
    end

    // Byte currently presented to the UART.
    always_comb begin
        case (idx_q)
            3'd0:    cur_byte = SOF;
            3'd1:    cur_byte = hdr_q;
            3'd2:    cur_byte = dhi_q;
            3'd3:    cur_byte = dlo_q;
            default: cur_byte = chk_q;
        endcase
    end

    // Outputs; TX_START is gated by TX_BUSY so no start overlaps a byte.
    always_comb begin
        sending    = (state_q == START) || (state_q == WAIT_HI) ||
                     (state_q == WAIT_LO);
        TX_START   = (state_q == START) && !TX_BUSY;
        TX_BYTE    = sending ? cur_byte : 8'h00;
        ACK_CELLAR = (state_q == ACK) && !room_q;
        ACK_MANOR  = (state_q == ACK) && room_q;
        BUSY       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_room_report_arbiter.sv
// Directed + randomized bench for room_report_arbiter with a behavioural
// UART and a frame-level reference model of arbitration and framing.
module tb_room_report_arbiter;

`ifdef ALARM_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_cellar = 1'b0;
    logic        req_manor = 1'b0;
    logic [15:0] data_cellar = 16'h0000;
    logic [15:0] data_manor = 16'h0000;
    logic        alarm_cellar = 1'b0;
    logic        alarm_manor = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        ack_cellar;
    logic        ack_manor;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   busy_len = 1;
    bit   force_busy = 1'b0;
    logic [7:0] bytes_q[$];
    int   first_start = -1;
    int   ack_count = 0;
    logic [7:0] last_byte = 8'h00;
    bit   tracking = 1'b0;

    int   m_seq = 0;
    bit   m_last = 1'b1;

    room_report_arbiter #(
        .SOF        (8'h55),
        .GAP_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .REQ_CELLAR   (req_cellar),
        .REQ_MANOR    (req_manor),
        .DATA_CELLAR  (data_cellar),
        .DATA_MANOR   (data_manor),
        .ALARM_CELLAR (alarm_cellar),
        .ALARM_MANOR  (alarm_manor),
        .TX_BUSY      (tx_busy),
        .TX_START     (tx_start),
        .TX_BYTE      (tx_byte),
        .ACK_CELLAR   (ack_cellar),
        .ACK_MANOR    (ack_manor),
        .BUSY         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART: busy for busy_len cycles starting the cycle after TX_START.
    initial begin
        bit st;
        int left;
        left = 0;
        forever begin
            @(negedge clk);
            st = tx_start;
            @(posedge clk);
            #2;
            if (force_busy) begin
                tx_busy = 1'b1;
            end else if (st) begin
                tx_busy = 1'b1;
                left = busy_len - 1;
            end else if (left > 0) begin
                left--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    // Byte/ACK monitor.
    always @(negedge clk) begin
        if (tx_start) begin
            chk("start_while_busy", tx_busy, 0);
            if (bytes_q.size() == 0) first_start = cyc;
            bytes_q.push_back(tx_byte);
            last_byte = tx_byte;
            tracking = 1'b1;
        end else if (rst) begin
            tracking = 1'b0;
        end else if (tracking && tx_busy) begin
            chk("byte_stable", tx_byte, last_byte);
        end else if (!tx_busy) begin
            tracking = 1'b0;
        end
        if (ack_cellar || ack_manor) ack_count++;
    end

    function automatic bit winner(bit rc, bit rm, bit ac, bit am);
        if (rc && !rm) return 1'b0;
        if (rm && !rc) return 1'b1;
        if (PRIO && (ac != am)) return am;
        return !m_last;
    endfunction

    task automatic wait_idle();
        for (int k = 0; k < 100 && busy !== 1'b0; k++) @(negedge clk);
        chk("idle_timeout", busy, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_cellar = 1'b0;
        req_manor = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_seq = 0;
        m_last = 1'b1;
    endtask

    task automatic do_frame(input bit rc, input bit rm,
                            input logic [15:0] dc, input logic [15:0] dm,
                            input bit ac, input bit am, input int blen,
                            input bit force10, input bit chk_lat,
                            input bit chk_gap);
        int n;
        int ack_cyc;
        bit w;
        bit acked;
        logic [7:0] hdr;
        logic [15:0] d;
        logic [7:0] e[5];
        wait_idle();
        @(posedge clk);
        #1;
        busy_len = blen;
        bytes_q.delete();
        first_start = -1;
        req_cellar = rc;
        req_manor = rm;
        data_cellar = dc;
        data_manor = dm;
        alarm_cellar = ac;
        alarm_manor = am;
        if (force10) force_busy = 1'b1;
        n = cyc;
        w = winner(rc, rm, ac, am);
        d = w ? dm : dc;
        hdr = {w, (w ? am : ac), 6'(m_seq)};
        e[0] = 8'h55;
        e[1] = hdr;
        e[2] = d[15:8];
        e[3] = d[7:0];
        e[4] = hdr ^ d[15:8] ^ d[7:0];
        if (force10) begin
            for (int k = 0; k < 10; k++) @(posedge clk);
            #1;
            force_busy = 1'b0;
        end
        acked = 1'b0;
        for (int k = 0; k < 400 && !acked; k++) begin
            @(negedge clk);
            if (ack_cellar || ack_manor) acked = 1'b1;
        end
        chk("ack_seen", acked, 1);
        ack_cyc = cyc;
        chk("ack_cellar", ack_cellar, !w);
        chk("ack_manor", ack_manor, w);
        if (chk_lat) chk("ack_latency", ack_cyc - n, 17);
        if (force10) chk("delayed_start", first_start - n, 10);
        chk("byte_count", bytes_q.size(), 5);
        for (int i = 0; i < 5 && i < bytes_q.size(); i++)
            chk($sformatf("frame_byte%0d", i), bytes_q[i], e[i]);
        m_seq = (m_seq + 1) % 64;
        m_last = w;
        @(posedge clk);
        #1;
        req_cellar = 1'b0;
        req_manor = 1'b0;
        if (chk_gap) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("busy_in_gap", busy, 1);
            end
            @(negedge clk);
            chk("busy_after_gap", busy, 0);
        end
    endtask

    initial begin
        int acks_before;
        int r;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_ack_cellar", ack_cellar, 0);
        chk("rst_ack_manor", ack_manor, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_frame(1, 0, 16'h1234, 16'h0000, 0, 0, 1, 0, 1, 1);

        pulse_reset();
        for (int f = 0; f < 4; f++)
            do_frame(1, 1, 16'hA000 + 16'(f), 16'hB000 + 16'(f),
                     0, 0, 1, 0, 1, 0);

        do_frame(0, 1, 16'h0F0F, 16'h7E81, 0, 0, 1, 0, 1, 0);
        do_frame(1, 1, 16'h1111, 16'h2222, 0, 1, 1, 0, 1, 0);

        wait_idle();
        @(posedge clk);
        #1;
        busy_len = 1;
        bytes_q.delete();
        req_cellar = 1'b1;
        data_cellar = 16'hBEEF;
        for (int k = 0; k < 100 && bytes_q.size() < 3; k++)
            @(negedge clk);
        chk("third_byte_started", bytes_q.size(), 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_cellar = 1'b0;
        acks_before = ack_count;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_seq = 0;
        m_last = 1'b1;
        @(negedge clk);
        chk("post_rst_start", tx_start, 0);
        chk("post_rst_busy", busy, 0);
        bytes_q.delete();
        repeat (30) @(negedge clk);
        chk("post_rst_no_bytes", bytes_q.size(), 0);
        chk("post_rst_no_ack", ack_count, acks_before);
        do_frame(1, 0, 16'hC0DE, 16'h0000, 0, 0, 1, 0, 1, 0);

        for (int f = 0; f < 64; f++) begin
            int bl;
            r = $urandom_range(1, 3);
            bl = $urandom_range(1, 3);
            do_frame(r[0], r[1], 16'($urandom), 16'($urandom),
                     1'($urandom), 1'($urandom), bl, 0, bl == 1, 0);
        end

        do_frame(0, 1, 16'h5AA5, 16'h3C3C, 0, 1, 1, 1, 0, 0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
